// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode constants and a
// ceiling-log2 helper used to size pointers and the occupancy counter.
package fifo_defs;

  localparam int FWFT_STANDARD    = 0;
  localparam int FWFT_FALLTHROUGH = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read handshake and status bundle between a FIFO and its user.
// The FIFO side uses the slave modport.
interface sync_fifo_if
  import fifo_defs::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
);

  localparam int CW = clog2(FIFO_DEPTH) + 1;

  logic                  push;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  pop;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;
  logic                  pushed_last;
  logic                  popped_last;
  logic                  fifo_ready;

  modport master (
    output push, in_data, pop,
    input  out_data, out_valid, full, empty, almost_full, almost_empty,
    input  count, overflow, underflow, pushed_last, popped_last, fifo_ready
  );

  modport slave (
    input  push, in_data, pop,
    output out_data, out_valid, full, empty, almost_full, almost_empty,
    output count, overflow, underflow, pushed_last, popped_last, fifo_ready
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for the FIFO. Contents are never reset; only the
// registered read port (standard mode) is cleared so out_data starts at zero.
module fifo_ram
  import fifo_defs::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = FWFT_STANDARD
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  rd_flush,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  generate
    if (FWFT == FWFT_STANDARD) begin : g_registered
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic [DATA_WIDTH-1:0] rd_data_d;

      // Same-edge write to the read address returns the old word.
      always_comb begin
        rd_data_d = rd_data_q;
        if (rd_flush) begin
          rd_data_d = '0;
        end else if (rd_en) begin
          rd_data_d = mem[rd_addr];
        end
      end

      always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
          rd_data_q <= '0;
        end else begin
          rd_data_q <= rd_data_d;
        end
      end

      assign rd_data = rd_data_q;
    end else begin : g_async
      logic unused_ctrl;
      assign unused_ctrl = ^{clear, rd_flush, rd_en};
      assign rd_data     = mem[rd_addr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with registered level flags, sticky
// overflow/underflow, fill/drain pulses and optional first-word-fall-through.
module sync_fifo
  import fifo_defs::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int FIFO_DEPTH         = 16,
  parameter int ALMOST_FULL_LEVEL  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter int FWFT               = FWFT_STANDARD
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       enable,
  input  logic       flush,
  sync_fifo_if.slave bus
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_LEVEL);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  pushed_last_q, pushed_last_d;
  logic                  popped_last_q, popped_last_d;
  logic                  push_acc;
  logic                  pop_acc;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // A full FIFO still accepts a push when a pop frees the slot this cycle.
  assign pop_acc  = enable & ~flush & bus.pop & (count_q != '0);
  assign push_acc = enable & ~flush & bus.push & ((count_q != DEPTH_C) | pop_acc);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    out_valid_d   = 1'b0;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;
    pushed_last_d = 1'b0;
    popped_last_d = 1'b0;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      out_valid_d   = (FWFT == FWFT_STANDARD) && pop_acc;
      overflow_d    = overflow_q | (enable & bus.push & full_q & ~pop_acc);
      underflow_d   = underflow_q | (enable & bus.pop & empty_q);
      pushed_last_d = push_acc & ~pop_acc & (count_q == DEPTH_C - CW'(1));
      popped_last_d = pop_acc & ~push_acc & (count_q == CW'(1));
    end

    full_d         = (count_d == DEPTH_C);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AF_C);
    almost_empty_d = (count_d <= AE_C);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      out_valid_q    <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      pushed_last_q  <= 1'b0;
      popped_last_q  <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      out_valid_q    <= out_valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      pushed_last_q  <= pushed_last_d;
      popped_last_q  <= popped_last_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (AW),
    .FWFT       (FWFT)
  ) u_ram (
    .clock    (clock),
    .clear    (clear),
    .rd_flush (flush),
    .wr_en    (push_acc),
    .wr_addr  (wr_ptr_q),
    .wr_data  (bus.in_data),
    .rd_en    (pop_acc),
    .rd_addr  (rd_ptr_q),
    .rd_data  (ram_rd_data)
  );

  generate
    if (FWFT == FWFT_STANDARD) begin : g_std_out
      assign bus.out_valid = out_valid_q;
      assign bus.out_data  = ram_rd_data;
    end else begin : g_fwft_out
      logic unused_valid;
      assign unused_valid  = out_valid_q;
      assign bus.out_valid = ~empty_q;
      assign bus.out_data  = empty_q ? '0 : ram_rd_data;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.pushed_last  = pushed_last_q & enable;
  assign bus.popped_last  = popped_last_q & enable;
  assign bus.fifo_ready   = enable & ~clear & ~flush;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: a standard-latency FIFO and a fall-through FIFO, both
// 8 bits wide and 4 words deep, driven by one linear stimulus sequence.
module tb_sync_fifo;

  logic clock;
  logic clear;
  logic enable;
  logic flush;
  int   checks;
  int   errors;

  sync_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) bus0 ();
  sync_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) bus1 ();

  sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .FWFT(0)) dut_std (
    .clock  (clock),
    .clear  (clear),
    .enable (enable),
    .flush  (flush),
    .bus    (bus0)
  );

  sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .FWFT(1)) dut_fwft (
    .clock  (clock),
    .clear  (clear),
    .enable (enable),
    .flush  (flush),
    .bus    (bus1)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic push, input logic [7:0] data,
                                input logic pop);
    bus0.push    = push;
    bus0.in_data = data;
    bus0.pop     = pop;
    tick();
    bus0.push = 1'b0;
    bus0.pop  = 1'b0;
  endtask

  task automatic apply_fwft(input logic push, input logic [7:0] data,
                            input logic pop);
    bus1.push    = push;
    bus1.in_data = data;
    bus1.pop     = pop;
    tick();
    bus1.push = 1'b0;
    bus1.pop  = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    clock        = 1'b0;
    clear        = 1'b1;
    enable       = 1'b1;
    flush        = 1'b0;
    bus0.push    = 1'b0;
    bus0.pop     = 1'b0;
    bus0.in_data = 8'h00;
    bus1.push    = 1'b0;
    bus1.pop     = 1'b0;
    bus1.in_data = 8'h00;

    tick();
    tick();
    check_output("rst_count", bus0.count, 0);
    check_output("rst_empty", bus0.empty, 1);
    check_output("rst_aempty", bus0.almost_empty, 1);
    check_output("rst_full", bus0.full, 0);
    check_output("rst_afull", bus0.almost_full, 0);
    check_output("rst_valid", bus0.out_valid, 0);
    check_output("rst_data", bus0.out_data, 0);
    check_output("rst_ready", bus0.fifo_ready, 0);
    clear = 1'b0;
    #1;
    check_output("ready_after_rst", bus0.fifo_ready, 1);

    $display("[TB] fill and overflow");
    apply_stimulus(1'b1, 8'h11, 1'b0);
    check_output("fill1_count", bus0.count, 1);
    check_output("fill1_empty", bus0.empty, 0);
    apply_stimulus(1'b1, 8'h22, 1'b0);
    check_output("fill2_afull", bus0.almost_full, 1);
    check_output("fill2_aempty", bus0.almost_empty, 1);
    apply_stimulus(1'b1, 8'h33, 1'b0);
    check_output("fill3_aempty", bus0.almost_empty, 0);
    check_output("fill3_plast", bus0.pushed_last, 0);
    apply_stimulus(1'b1, 8'h44, 1'b0);
    check_output("fill4_count", bus0.count, 4);
    check_output("fill4_full", bus0.full, 1);
    check_output("fill4_plast", bus0.pushed_last, 1);
    apply_stimulus(1'b1, 8'h55, 1'b0);
    check_output("ovf_flag", bus0.overflow, 1);
    check_output("ovf_count", bus0.count, 4);
    check_output("ovf_plast", bus0.pushed_last, 0);

    $display("[TB] drain and underflow");
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("pop1_data", bus0.out_data, 8'h11);
    check_output("pop1_valid", bus0.out_valid, 1);
    check_output("pop1_count", bus0.count, 3);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("pop2_data", bus0.out_data, 8'h22);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("pop3_data", bus0.out_data, 8'h33);
    check_output("pop3_qlast", bus0.popped_last, 0);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("pop4_data", bus0.out_data, 8'h44);
    check_output("pop4_qlast", bus0.popped_last, 1);
    check_output("pop4_empty", bus0.empty, 1);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("idle_valid", bus0.out_valid, 0);
    check_output("idle_hold", bus0.out_data, 8'h44);
    check_output("idle_qlast", bus0.popped_last, 0);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("udf_flag", bus0.underflow, 1);
    check_output("udf_valid", bus0.out_valid, 0);
    check_output("ovf_sticky", bus0.overflow, 1);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_output("flush_ovf", bus0.overflow, 0);
    check_output("flush_udf", bus0.underflow, 0);
    check_output("flush_data", bus0.out_data, 0);

    $display("[TB] simultaneous push/pop on full");
    apply_stimulus(1'b1, 8'h11, 1'b0);
    apply_stimulus(1'b1, 8'h22, 1'b0);
    apply_stimulus(1'b1, 8'h33, 1'b0);
    apply_stimulus(1'b1, 8'h44, 1'b0);
    apply_stimulus(1'b1, 8'h66, 1'b1);
    check_output("both_count", bus0.count, 4);
    check_output("both_data", bus0.out_data, 8'h11);
    check_output("both_ovf", bus0.overflow, 0);
    check_output("both_plast", bus0.pushed_last, 0);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("wrap1_data", bus0.out_data, 8'h22);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("wrap2_data", bus0.out_data, 8'h33);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("wrap3_data", bus0.out_data, 8'h44);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("wrap4_data", bus0.out_data, 8'h66);
    check_output("wrap4_empty", bus0.empty, 1);

    $display("[TB] flush with push");
    apply_stimulus(1'b1, 8'hAA, 1'b0);
    apply_stimulus(1'b1, 8'hBB, 1'b0);
    apply_stimulus(1'b1, 8'hCC, 1'b0);
    check_output("pre_flush_count", bus0.count, 3);
    flush = 1'b1;
    #1;
    check_output("flush_ready", bus0.fifo_ready, 0);
    apply_stimulus(1'b1, 8'hDD, 1'b0);
    flush = 1'b0;
    check_output("fpush_count", bus0.count, 0);
    check_output("fpush_empty", bus0.empty, 1);
    check_output("fpush_ovf", bus0.overflow, 0);
    apply_stimulus(1'b1, 8'hEE, 1'b0);
    check_output("post_flush_count", bus0.count, 1);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("post_flush_data", bus0.out_data, 8'hEE);
    check_output("post_flush_qlast", bus0.popped_last, 1);

    $display("[TB] enable low");
    enable = 1'b0;
    #1;
    check_output("dis_ready", bus0.fifo_ready, 0);
    apply_stimulus(1'b1, 8'h12, 1'b0);
    check_output("dis_count", bus0.count, 0);
    check_output("dis_ovf", bus0.overflow, 0);
    enable = 1'b1;

    $display("[TB] clear mid-burst");
    apply_stimulus(1'b1, 8'h01, 1'b0);
    apply_stimulus(1'b1, 8'h02, 1'b0);
    check_output("burst_count", bus0.count, 2);
    bus0.push    = 1'b1;
    bus0.in_data = 8'h03;
    clear        = 1'b1;
    #1;
    check_output("clr_count", bus0.count, 0);
    check_output("clr_empty", bus0.empty, 1);
    check_output("clr_aempty", bus0.almost_empty, 1);
    check_output("clr_full", bus0.full, 0);
    check_output("clr_afull", bus0.almost_full, 0);
    check_output("clr_data", bus0.out_data, 0);
    check_output("clr_valid", bus0.out_valid, 0);
    check_output("clr_ovf", bus0.overflow, 0);
    check_output("clr_udf", bus0.underflow, 0);
    check_output("clr_plast", bus0.pushed_last, 0);
    check_output("clr_qlast", bus0.popped_last, 0);
    check_output("clr_ready", bus0.fifo_ready, 0);
    tick();
    bus0.push = 1'b0;
    clear     = 1'b0;
    #1;
    check_output("clr_abort_count", bus0.count, 0);
    apply_stimulus(1'b1, 8'h77, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("after_clr_data", bus0.out_data, 8'h77);
    check_output("after_clr_valid", bus0.out_valid, 1);

    $display("[TB] first-word-fall-through");
    check_output("fwft_idle_valid", bus1.out_valid, 0);
    apply_fwft(1'b1, 8'hA5, 1'b0);
    check_output("fwft_valid", bus1.out_valid, 1);
    check_output("fwft_data", bus1.out_data, 8'hA5);
    apply_fwft(1'b1, 8'hB6, 1'b0);
    check_output("fwft_head_hold", bus1.out_data, 8'hA5);
    check_output("fwft_count", bus1.count, 2);
    apply_fwft(1'b0, 8'h00, 1'b1);
    check_output("fwft_advance", bus1.out_data, 8'hB6);
    apply_fwft(1'b0, 8'h00, 1'b1);
    check_output("fwft_empty_valid", bus1.out_valid, 0);
    check_output("fwft_qlast", bus1.popped_last, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
